// File: rtl/mem_align_unit_if.sv
// CPU-side request/response and data-memory port bundle for mem_align_unit.
// The slave modport is the aligner's view; master is the CPU/memory-model view.
interface mem_align_unit_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
);
  localparam int NB = WIDTH / 8;

  logic                  cpu_read;
  logic                  cpu_write;
  logic                  cpu_byte;
  logic                  cpu_signed;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [WIDTH-1:0]      cpu_wdata;
  logic [WIDTH-1:0]      cpu_rdata;
  logic                  cpu_resp;
  logic                  cpu_misalign;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [NB-1:0]         mem_byte_enable;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  cpu_read, cpu_write, cpu_byte, cpu_signed, cpu_address, cpu_wdata,
    input  mem_rdata, mem_resp,
    output cpu_rdata, cpu_resp, cpu_misalign,
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_byte, cpu_signed, cpu_address, cpu_wdata,
    output mem_rdata, mem_resp,
    input  cpu_rdata, cpu_resp, cpu_misalign,
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
  );
endinterface

// File: rtl/mem_align_unit.sv
// Byte-lane aligner and req/resp sequencer between the MEM stage and data memory.
// Define UNALIGNED_SPLIT_EN to split misaligned word accesses into two beats; otherwise they are refused.
module mem_align_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  mem_align_unit_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OW-1:0]         off_q, off_d;
  logic                  byte_q, byte_d, signed_q, signed_d, write_q, write_d;
`ifdef UNALIGNED_SPLIT_EN
  logic [WIDTH-1:0]      wdata_q, wdata_d, low_q, low_d;
  logic                  split_q, split_d;
`endif
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [NB-1:0]         mem_be_q, mem_be_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d, cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_resp_q, cpu_resp_d, cpu_misalign_q, cpu_misalign_d;

  logic [OW-1:0]         off_in;
  logic [ADDR_WIDTH-1:0] base_in;
  logic                  misaligned, refuse, finish;
  logic [WIDTH-1:0]      result;

  // Lane enables: the second beat of a split covers exactly the lanes the first beat skipped.
  function automatic logic [NB-1:0] beat_be(input logic is_byte, input logic [OW-1:0] off,
                                            input logic second);
    logic [NB-1:0] first;
    first = is_byte ? ({{(NB-1){1'b0}}, 1'b1} << off) : ({NB{1'b1}} << off);
    return second ? ~first : first;
  endfunction

  function automatic logic [WIDTH-1:0] beat_wdata(input logic is_byte, input logic [OW-1:0] off,
                                                  input logic second, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] src;
    src = is_byte ? {{(WIDTH-8){1'b0}}, wd[7:0]} : wd;
    if (second) return src >> (8 * (NB - int'(off)));
    return src << (8 * int'(off));
  endfunction

  function automatic logic [WIDTH-1:0] byte_ext(input logic [WIDTH-1:0] rd, input logic [OW-1:0] off,
                                                input logic sgn);
    logic [7:0] b;
    b = 8'(rd >> (8 * int'(off)));
    return sgn ? {{(WIDTH-8){b[7]}}, b} : {{(WIDTH-8){1'b0}}, b};
  endfunction

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    off_d          = off_q;
    byte_d         = byte_q;
    signed_d       = signed_q;
    write_d        = write_q;
`ifdef UNALIGNED_SPLIT_EN
    wdata_d        = wdata_q;
    low_d          = low_q;
    split_d        = split_q;
`endif
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_address_d  = mem_address_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_rdata_d    = '0;
    cpu_resp_d     = 1'b0;
    cpu_misalign_d = 1'b0;
    refuse         = 1'b0;
    finish         = 1'b0;
    result         = '0;
    off_in         = bus.cpu_address[OW-1:0];
    base_in        = {bus.cpu_address[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    misaligned     = !bus.cpu_byte && (off_in != '0);

    case (state_q)
      IDLE: begin
        if (bus.cpu_read || bus.cpu_write) begin
          base_d   = base_in;
          off_d    = off_in;
          byte_d   = bus.cpu_byte;
          signed_d = bus.cpu_signed;
          write_d  = bus.cpu_write;
`ifdef UNALIGNED_SPLIT_EN
          wdata_d  = bus.cpu_wdata;
          split_d  = misaligned;
`else
          refuse   = misaligned;
`endif
          if (refuse) begin
            state_d        = DONE;
            cpu_resp_d     = 1'b1;
            cpu_misalign_d = 1'b1;
          end else begin
            state_d       = BEAT1;
            mem_write_d   = bus.cpu_write;
            mem_read_d    = !bus.cpu_write;
            mem_address_d = base_in;
            mem_be_d      = beat_be(bus.cpu_byte, off_in, 1'b0);
            mem_wdata_d   = bus.cpu_write ? beat_wdata(bus.cpu_byte, off_in, 1'b0, bus.cpu_wdata) : '0;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_resp) begin
`ifdef UNALIGNED_SPLIT_EN
          if (split_q) begin
            state_d       = BEAT2;
            mem_address_d = base_q + ADDR_WIDTH'(NB);
            mem_be_d      = beat_be(1'b0, off_q, 1'b1);
            mem_wdata_d   = write_q ? beat_wdata(1'b0, off_q, 1'b1, wdata_q) : '0;
            low_d         = bus.mem_rdata >> (8 * int'(off_q));
          end else
`endif
          begin
            finish = 1'b1;
            result = byte_q ? byte_ext(bus.mem_rdata, off_q, signed_q) : bus.mem_rdata;
          end
        end
      end
`ifdef UNALIGNED_SPLIT_EN
      BEAT2: begin
        if (bus.mem_resp) begin
          finish = 1'b1;
          result = (bus.mem_rdata << (8 * (NB - int'(off_q)))) | low_q;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d       = DONE;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_address_d = '0;
      mem_be_d      = '0;
      mem_wdata_d   = '0;
      cpu_resp_d    = 1'b1;
      cpu_rdata_d   = write_q ? '0 : result;
    end
  end

  // Control and visible outputs reset; latched request fields are don't-care until the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_be_q       <= '0;
      mem_wdata_q    <= '0;
      cpu_rdata_q    <= '0;
      cpu_resp_q     <= 1'b0;
      cpu_misalign_q <= 1'b0;
`ifdef UNALIGNED_SPLIT_EN
      split_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_address_q  <= mem_address_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_resp_q     <= cpu_resp_d;
      cpu_misalign_q <= cpu_misalign_d;
`ifdef UNALIGNED_SPLIT_EN
      split_q        <= split_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    base_q   <= base_d;
    off_q    <= off_d;
    byte_q   <= byte_d;
    signed_q <= signed_d;
    write_q  <= write_d;
`ifdef UNALIGNED_SPLIT_EN
    wdata_q  <= wdata_d;
    low_q    <= low_d;
`endif
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.cpu_rdata       = cpu_rdata_q;
  assign bus.cpu_resp        = cpu_resp_q;
  assign bus.cpu_misalign    = cpu_misalign_q;
endmodule
